// File: rtl/deserializer.sv
// SPI-slave (mode 0) instruction deserializer: resynchronises {opcode, key_addr, text_addr}
// into clk and hands it off on a pending/ready handshake. `define DESER_OVERRUN_EN adds an overrun pulse.
module deserializer #(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_clk,
  input  logic               mosi,
  input  logic               cs_n,
  input  logic               ready_in,
  output logic [OPCODEW-1:0] opcode,
  output logic [ADDRW-1:0]   key_addr,
  output logic [ADDRW-1:0]   text_addr,
`ifdef DESER_OVERRUN_EN
  output logic               overrun,
`endif
  output logic               valid_out
);
  localparam int SHIFT_W = OPCODEW + 2*ADDRW;
  localparam int CNTW    = $clog2(SHIFT_W + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(SHIFT_W);

  logic [2:0]         sclk_s;
  logic [1:0]         cs_s, mosi_s;
  logic               sclk_rise, cs_sync;
  logic [SHIFT_W-1:0] shift;
  logic [CNTW-1:0]    cnt;
  logic               busy, blocked, load, shift_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= 2'b11;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_clk};
      cs_s   <= {cs_s[0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign cs_sync   = cs_s[1];
  assign load      = (cnt == FULL);
  // blocked keeps a completed or busy-overlapped frame from re-arming until cs_n rises
  assign shift_en  = ~cs_sync & ~busy & ~blocked & sclk_rise & (cnt < FULL);
  assign valid_out = busy & ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      blocked   <= 1'b0;
      opcode    <= '0;
      key_addr  <= '0;
      text_addr <= '0;
    end else begin
      if (load) cnt <= '0;
      else if (cs_sync) begin
        cnt   <= '0;
        shift <= '0;
      end else if (shift_en) begin
        shift <= {shift[SHIFT_W-2:0], mosi_s[1]};
        cnt   <= cnt + 1'b1;
      end
      blocked <= cs_sync ? 1'b0 : (blocked | busy | load);
      // load wins over the handshake: a new frame landing as the old one drains stays pending
      if (load) begin
        busy      <= 1'b1;
        opcode    <= shift[SHIFT_W-1 -: OPCODEW];
        key_addr  <= shift[SHIFT_W-OPCODEW-1 -: ADDRW];
        text_addr <= shift[ADDRW-1:0];
      end else if (valid_out) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef DESER_OVERRUN_EN
  logic [CNTW-1:0] ovr_cnt;

  // frames arriving while busy are only counted, never shifted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= ~cs_sync & busy & sclk_rise & (ovr_cnt == FULL - 1'b1);
      if (cs_sync) ovr_cnt <= '0;
      else if (busy && sclk_rise && ovr_cnt != FULL) ovr_cnt <= ovr_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_deserializer.sv
// Directed + random bench for deserializer: frames are driven on a behavioural SPI master and
// delivered fields are compared against a queue of frames the bench expects to be handed off.
module tb_deserializer;
  logic       clk = 0, rst_n = 0, spi_clk = 0, mosi = 0, cs_n = 1, ready_in = 0;
  logic [1:0] opcode;
  logic [7:0] key_addr, text_addr;
  logic       valid_out;
  int         n_chk = 0, n_fail = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  int         dbl = 0, ovr_pulses = 0;
  logic       prev_v = 0;

`ifdef DESER_OVERRUN_EN
  logic overrun;
`endif

  deserializer dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n),
    .ready_in(ready_in), .opcode(opcode), .key_addr(key_addr), .text_addr(text_addr),
`ifdef DESER_OVERRUN_EN
    .overrun(overrun),
`endif
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // delivered frames as observed by a downstream consumer
  always @(negedge clk) begin
    if (valid_out) got_q.push_back({opcode, key_addr, text_addr});
    if (valid_out && prev_v) dbl++;
    prev_v = valid_out;
`ifdef DESER_OVERRUN_EN
    if (overrun) ovr_pulses++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drives the top n bits of f MSB-first, mode 0, then raises cs_n with an 80 ns gap
  task automatic send(input logic [17:0] f, input int n);
    cs_n = 0; #40;
    for (int i = 17; i > 17 - n; i--) begin
      mosi = f[i]; #40; spi_clk = 1; #40; spi_clk = 0;
    end
    #40; cs_n = 1; mosi = 0; #80;
  endtask

  // compares every delivered frame against the expected queue, then empties both
  task automatic check_delivered(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_frame%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
  endtask

  function automatic logic [17:0] fr(input logic [1:0] op, input logic [7:0] k, input logic [7:0] t);
    return {op, k, t};
  endfunction

  initial begin
    logic [17:0] f;
    #120;
    chk("rst_valid", valid_out, 0);
    chk("rst_fields", {opcode, key_addr, text_addr}, 0);
`ifdef DESER_OVERRUN_EN
    chk("rst_overrun", overrun, 0);
`endif
    rst_n = 1; #20;

    ready_in = 1;
    send(fr(2'b01, 8'hAA, 8'h55), 18); #200;
    exp_q.push_back(fr(2'b01, 8'hAA, 8'h55));
    check_delivered("basic");

    send(fr(2'b10, 8'h0F, 8'hF0), 9); #300;
    check_delivered("abort");
    chk("abort_hold", {opcode, key_addr, text_addr}, fr(2'b01, 8'hAA, 8'h55));

    ready_in = 0;
    send(fr(2'b10, 8'h0F, 8'hF0), 18); #600;
    check_delivered("wait_none");
    ready_in = 1; #100;
    exp_q.push_back(fr(2'b10, 8'h0F, 8'hF0));
    check_delivered("wait_go");

    ready_in = 0; ovr_pulses = 0;
    send(fr(2'b11, 8'h5A, 8'hC3), 18);
    send(fr(2'b01, 8'hAA, 8'h55), 18); #100;
    ready_in = 1; #600;
    exp_q.push_back(fr(2'b11, 8'h5A, 8'hC3));
    check_delivered("overrun_keep");
`ifdef DESER_OVERRUN_EN
    chk("overrun_pulse", ovr_pulses, 1);
`endif

    cs_n = 0; #40;
    for (int i = 0; i < 10; i++) begin
      mosi = i[0]; #40; spi_clk = 1; #40; spi_clk = 0;
    end
    rst_n = 0; #30; cs_n = 1; mosi = 0; #30;
    chk("midrst_fields", {opcode, key_addr, text_addr}, 0);
    rst_n = 1; #80;
    send(fr(2'b01, 8'hAA, 8'h55), 18); #200;
    exp_q.push_back(fr(2'b01, 8'hAA, 8'h55));
    check_delivered("midrst");

    for (int n = 0; n < 6; n++) begin
      f = 18'($urandom);
      exp_q.push_back(f);
      send(f, 18);
    end
    #200;
    check_delivered("b2b");
    chk("no_double", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
